vram_fetch_arbiter: RTL

VRAM_FETCH_ARBITER -- requirements
Module: vram_fetch_arbiter

---
 rtl/video_pkg.sv | 19 +
 rtl/vram_fetch_arbiter_if.sv | 21 ++
 rtl/pixel_fifo.sv | 56 +++++
 rtl/vram_fetch_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and defaults for the VRAM fetch arbiter: arbiter states,
// FIFO/line defaults and the video address helper.
package video_pkg;

  localparam int unsigned DefaultFifoDepth     = 4;
  localparam int unsigned DefaultPixelsPerLine = 256;

  typedef enum logic [1:0] {
    IDLE,
    VIDEO_RD,
    HOST_RD,
    HOST_WR
  } arb_state_e;

  function automatic logic [15:0] video_addr(input logic [7:0] row, input logic [7:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vram_fetch_arbiter_if.sv
// Host-side VRAM access bus: a level request held until a one-clock ack.
interface vram_fetch_arbiter_if;

  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous pixel prefetch FIFO with occupancy count; push and pop may
// share a clock, and flush empties it in one clock.
module pixel_fifo
  import video_pkg::*;
#(
  parameter int unsigned Depth = DefaultFifoDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic [7:0]              head,
  output logic [$clog2(Depth):0]  count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(Depth);

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != Full) || do_pop);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers qualify
  // every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Single-port VRAM arbiter: line-based pixel prefetch into a small FIFO with
// absolute priority, host reads/writes filling the remaining slots.
module vram_fetch_arbiter
  import video_pkg::*;
#(
  parameter int unsigned FifoDepth     = DefaultFifoDepth,
  parameter int unsigned PixelsPerLine = DefaultPixelsPerLine
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newline,
  input  logic                 newframe,
  input  logic                 newpixel,
  input  logic                 visible_line,
  output logic [15:0]          vram_addr,
  output logic                 vram_we,
  output logic [7:0]           vram_wdata,
  input  logic [7:0]           vram_rdata,
  vram_fetch_arbiter_if.slave  host,
  output logic [7:0]           pixel_data,
  output logic                 underrun
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;
  localparam logic [CntW:0] DepthLimit = (CntW + 1)'(FifoDepth);
  localparam logic [7:0]    LastCol    = 8'(PixelsPerLine - 1);

  arb_state_e      state;
  arb_state_e      next_state;
  logic            fetch_active;
  logic            line_was_visible;
  logic            video_pend;
  logic            host_ack_q;
  logic            rd_ack_q;
  logic [7:0]      row;
  logic [7:0]      col;
  logic [7:0]      rdata_hold;
  logic [7:0]      fifo_head;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   outstanding;
  logic            restart;
  logic            host_busy;
  logic            video_ok;
  logic            host_ok;
  logic            fifo_push;

  assign restart   = newline && visible_line;
  assign host_busy = (state == HOST_RD) || (state == HOST_WR);

  // Reads issued now or awaiting data both count against FIFO space.
  assign outstanding = {1'b0, fifo_count}
                     + (CntW + 1)'(state == VIDEO_RD)
                     + (CntW + 1)'(video_pend);

  assign video_ok  = fetch_active && (outstanding < DepthLimit);
  assign host_ok   = host.host_req && !host_busy && !host_ack_q;
  assign fifo_push = video_pend && !restart;

  // NOTE: next_state is given a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = IDLE;
    // The restart clock idles so the host cannot slip ahead of the refill.
    if (!restart) begin
      if (video_ok)     next_state = VIDEO_RD;
      else if (host_ok) next_state = host.host_we ? HOST_WR : HOST_RD;
    end
  end

  pixel_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (restart),
    .push      (fifo_push),
    .push_data (vram_rdata),
    .pop       (newpixel),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      fetch_active     <= 1'b0;
      line_was_visible <= 1'b0;
      row              <= '0;
      col              <= '0;
      video_pend       <= 1'b0;
      host_ack_q       <= 1'b0;
      rd_ack_q         <= 1'b0;
      rdata_hold       <= '0;
      vram_addr        <= '0;
      vram_we          <= 1'b0;
      vram_wdata       <= '0;
      pixel_data       <= '0;
      underrun         <= 1'b0;
    end else begin
      state      <= next_state;
      vram_we    <= (next_state == HOST_WR);
      video_pend <= (state == VIDEO_RD) && !restart;
      host_ack_q <= host_busy;
      rd_ack_q   <= (state == HOST_RD);
      if (rd_ack_q) rdata_hold <= vram_rdata;

      case (next_state)
        VIDEO_RD: vram_addr <= video_addr(row, col);
        HOST_RD:  vram_addr <= host.host_addr;
        HOST_WR: begin
          vram_addr  <= host.host_addr;
          vram_wdata <= host.host_wdata;
        end
        default: ;
      endcase

      if (restart) begin
        fetch_active <= 1'b1;
        col          <= '0;
      end else begin
        if (next_state == VIDEO_RD) col <= col + 1'b1;
        if (newline || ((next_state == VIDEO_RD) && (col == LastCol))) fetch_active <= 1'b0;
      end

      if (newframe)                          row <= '0;
      else if (newline && line_was_visible)  row <= row + 1'b1;

      if (newline)       line_was_visible <= visible_line;
      else if (newframe) line_was_visible <= 1'b0;

      if (newpixel) begin
        if (fifo_count == '0) begin
          pixel_data <= '0;
          underrun   <= 1'b1;
        end else begin
          pixel_data <= fifo_head;
        end
      end
    end
  end

  // Read data arrives in the ack clock itself, so it is forwarded then held.
  assign host.host_ack   = host_ack_q;
  assign host.host_rdata = rd_ack_q ? vram_rdata : rdata_hold;

endmodule
